start_controller: RTL and testbench

- Upstream of the clock corrector: turns a raw, asynchronous push-button/host start request into the clean, glitch-free start level that the clock corrector consumes.
- Synchronises and debounces the request, then waits a programmable settle delay.
- Holds start high for the whole matrix-multiplication run and drops it when the cores report done.
- Re-arms only after the request input is released.

---
 rtl/start_controller_if.sv | 31 +++
 rtl/start_controller.sv | 164 ++++++++++++++++
 tb/tb_start_controller.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/start_controller_if.sv
// Handshake bundle between the start controller and its environment.
// The controller side uses the slave modport; whoever drives the request
// and done inputs (host logic or a testbench) uses the master modport.
interface start_controller_if #(
    parameter int CNT_W = 8
);
    logic             btn_in;
    logic             proc_done;
    logic             start;
    logic             busy;
    logic [CNT_W-1:0] run_count;
    logic             timeout;

    modport master (
        output btn_in,
        output proc_done,
        input  start,
        input  busy,
        input  run_count,
        input  timeout
    );

    modport slave (
        input  btn_in,
        input  proc_done,
        output start,
        output busy,
        output run_count,
        output timeout
    );
endinterface

// File: rtl/start_controller.sv
// Start controller: turns a raw asynchronous start request into a clean,
// registered start level for the clock corrector. The request is
// synchronised, debounced, followed by a settle delay, then start is held
// until the matrix cores report done. A held request never starts a second
// run; the controller re-arms only after the request is released.
//
// Optional watchdog: define START_CTRL_WATCHDOG_EN to abort a run that
// lasts TIMEOUT_CYCLES without proc_done (sets the sticky timeout flag).
module start_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 4,
    parameter int CNT_W           = 8,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    start_controller_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        SETTLE,
        RUN,
        RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DEB_END = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] SET_END = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] runs;
    logic [CNT_W-1:0] runs_next;
    logic             start_q;
    logic             start_next;
    logic             timeout_q;
    logic             timeout_next;
    logic             sync_a;
    logic             btn_s;
    logic             wd_expired;

    // Counter never wraps inside a state; it sticks at all-ones.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

`ifdef START_CTRL_WATCHDOG_EN
    localparam int             WD_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_END = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    // Watchdog counts cycles spent in RUN and restarts whenever RUN is left.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == RUN) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign wd_expired = (wd_cnt == WD_END);
`else
    // Keeps the watchdog limit referenced when the watchdog is compiled out.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign wd_expired = 1'b0;
`endif

    // Two-flop synchroniser; only the second flop feeds the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_a <= bus.btn_in;
            btn_s  <= sync_a;
        end
    end

    // State, counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            runs      <= '0;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            runs      <= runs_next;
            start_q   <= start_next;
            timeout_q <= timeout_next;
        end
    end

    // Next-state logic; start is derived from the next state so it is a
    // plain flop output and is already high in the first RUN cycle.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        runs_next    = runs;
        timeout_next = timeout_q;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (btn_s) begin
                    state_next = DEBOUNCE;
                    cnt_next   = CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DEB_END) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            SETTLE: begin
                if (cnt == SET_END) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            RUN: begin
                if (bus.proc_done) begin
                    state_next = RELEASE;
                    runs_next  = runs + 1'b1;
                end else if (wd_expired) begin
                    state_next   = RELEASE;
                    timeout_next = 1'b1;
                end
            end
            RELEASE: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        start_next = (state_next == RUN);
    end

    assign bus.start     = start_q;
    assign bus.busy      = (state != IDLE);
    assign bus.run_count = runs;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_start_controller.sv
// Testbench for start_controller. Two instances share stimulus: one with
// default debounce/settle and an 8-bit counter, one with CNT_W=2 to exercise
// run_count wrap. Start edges of the first instance are checked against a
// scoreboard of expected edge cycles filled when stimulus is driven.
module tb_start_controller;

    localparam int DEB_A   = 16;
    localparam int SET_A   = 4;
    localparam int DEB_B   = 3;
    localparam int SET_B   = 2;
    localparam int TIMEOUT = 64;
    localparam int LAT_A   = DEB_A + SET_A + 4;

    typedef struct {
        int cyc;
        int cnt;
    } fall_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    int    runs_a = 0;
    int    runs_b = 0;
    int    exp_rise[$];
    fall_t exp_fall[$];
    int    mon_rise;
    fall_t mon_fall;
    logic  prev_start = 1'b0;
    int    wrap_exp[4] = '{1, 2, 3, 0};

    start_controller_if #(.CNT_W(8)) bus_a ();
    start_controller_if #(.CNT_W(2)) bus_b ();

    start_controller #(
        .DEBOUNCE_CYCLES(DEB_A),
        .SETTLE_CYCLES  (SET_A),
        .CNT_W          (8),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    start_controller #(
        .DEBOUNCE_CYCLES(DEB_B),
        .SETTLE_CYCLES  (SET_B),
        .CNT_W          (2),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index; value after an edge is the number of that edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic btn, input logic done);
        bus_a.btn_in    = btn;
        bus_a.proc_done = done;
        bus_b.btn_in    = btn;
        bus_b.proc_done = done;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectFall(input int at, input int cnt);
        fall_t f;
        f.cyc = at;
        f.cnt = cnt;
        exp_fall.push_back(f);
    endtask

    task automatic waitStart(input logic level, input int budget, input string tag);
        int n = 0;
        while (bus_a.start !== level && n < budget) begin
            step(1);
            n++;
        end
        if (bus_a.start !== level) checkOutput(tag, 32'(bus_a.start), 32'(level));
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int n = 0;
        while (bus_a.busy !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        if (bus_a.busy !== 1'b0) checkOutput(tag, 32'(bus_a.busy), 0);
    endtask

    task automatic doRun(input int hold);
        applyStimulus(1'b1, 1'b0);
        exp_rise.push_back(cyc + LAT_A);
        waitStart(1'b1, LAT_A + 10, "run_rise_wait");
        step(hold);
        applyStimulus(1'b1, 1'b1);
        runs_a++;
        runs_b = (runs_b + 1) % 4;
        expectFall(cyc + 1, runs_a);
        step(1);
        applyStimulus(1'b0, 1'b0);
        waitIdle(10, "run_idle_wait");
    endtask

    // Scoreboard side: every start edge of dut_a must match the next
    // expected edge cycle (and run count on falling edges).
    always @(negedge clk) begin
        if (bus_a.start === 1'b1 && prev_start === 1'b0) begin
            if (exp_rise.size() == 0) begin
                checkOutput("unexpected_rise", 1, 0);
            end else begin
                mon_rise = exp_rise.pop_front();
                checkOutput("rise_cycle", cyc, mon_rise);
            end
        end
        if (bus_a.start === 1'b0 && prev_start === 1'b1) begin
            if (exp_fall.size() == 0) begin
                checkOutput("unexpected_fall", 1, 0);
            end else begin
                mon_fall = exp_fall.pop_front();
                checkOutput("fall_cycle", cyc, mon_fall.cyc);
                checkOutput("fall_run_count", 32'(bus_a.run_count), mon_fall.cnt);
            end
        end
        prev_start <= bus_a.start;
    end

    // Main stimulus sequence.
    initial begin
        applyStimulus(1'b0, 1'b0);
        rst_n = 1'b0;
        step(3);
        checkOutput("rst_start_a", 32'(bus_a.start), 0);
        checkOutput("rst_busy_a", 32'(bus_a.busy), 0);
        checkOutput("rst_runs_a", 32'(bus_a.run_count), 0);
        checkOutput("rst_timeout_a", 32'(bus_a.timeout), 0);
        checkOutput("rst_busy_b", 32'(bus_b.busy), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            checkOutput("idle_start", 32'(bus_a.start), 0);
            checkOutput("idle_busy", 32'(bus_a.busy), 0);
            checkOutput("idle_runs", 32'(bus_a.run_count), 0);
        end

        // Press and hold; done arrives 30 cycles after start rises.
        applyStimulus(1'b1, 1'b0);
        exp_rise.push_back(cyc + LAT_A);
        waitStart(1'b1, LAT_A + 10, "press_rise_wait");
        checkOutput("press_busy", 32'(bus_a.busy), 1);
        step(29);
        checkOutput("press_start_held", 32'(bus_a.start), 1);
        applyStimulus(1'b1, 1'b1);
        runs_a++;
        runs_b = (runs_b + 1) % 4;
        expectFall(cyc + 1, runs_a);
        step(1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("press_start_low", 32'(bus_a.start), 0);
        checkOutput("press_runs_a", 32'(bus_a.run_count), 1);
        checkOutput("press_runs_b", 32'(bus_b.run_count), 1);
        step(40);
        checkOutput("held_busy", 32'(bus_a.busy), 1);
        checkOutput("held_start", 32'(bus_a.start), 0);
        applyStimulus(1'b0, 1'b0);
        step(3);
        checkOutput("release_busy_a", 32'(bus_a.busy), 0);
        checkOutput("release_busy_b", 32'(bus_b.busy), 0);

        // Bouncing request: never stable long enough for dut_a.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(i % 2 == 0, 1'b0);
            step(5);
        end
        applyStimulus(1'b0, 1'b0);
        step(5);
        checkOutput("bounce_busy", 32'(bus_a.busy), 0);
        checkOutput("bounce_start", 32'(bus_a.start), 0);

        // Reset for one edge, 10 cycles into a run.
        applyStimulus(1'b1, 1'b0);
        exp_rise.push_back(cyc + LAT_A);
        waitStart(1'b1, LAT_A + 10, "rst_rise_wait");
        step(10);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        expectFall(cyc + 1, 0);
        step(1);
        checkOutput("midrst_start", 32'(bus_a.start), 0);
        checkOutput("midrst_busy", 32'(bus_a.busy), 0);
        checkOutput("midrst_runs_a", 32'(bus_a.run_count), 0);
        checkOutput("midrst_runs_b", 32'(bus_b.run_count), 0);
        checkOutput("midrst_busy_b", 32'(bus_b.busy), 0);
        rst_n = 1'b1;
        runs_a = 0;
        runs_b = 0;

        // Four runs: the 2-bit counter wraps 1,2,3,0.
        for (int k = 0; k < 4; k++) begin
            doRun(5);
            checkOutput("wrap_runs_b", 32'(bus_b.run_count), wrap_exp[k]);
            checkOutput("wrap_runs_a", 32'(bus_a.run_count), k + 1);
        end

        // Run with no done at all.
        applyStimulus(1'b1, 1'b0);
        exp_rise.push_back(cyc + LAT_A);
        waitStart(1'b1, LAT_A + 10, "wd_rise_wait");
`ifdef START_CTRL_WATCHDOG_EN
        expectFall(cyc + TIMEOUT, runs_a);
        waitStart(1'b0, TIMEOUT + 10, "wd_fall_wait");
        checkOutput("wd_timeout", 32'(bus_a.timeout), 1);
        checkOutput("wd_runs", 32'(bus_a.run_count), 4);
        applyStimulus(1'b0, 1'b0);
        waitIdle(10, "wd_idle_wait");
        checkOutput("wd_sticky_release", 32'(bus_a.timeout), 1);
        doRun(5);
        checkOutput("wd_sticky_run", 32'(bus_a.timeout), 1);
        checkOutput("wd_runs_after", 32'(bus_a.run_count), 5);
`else
        for (int i = 0; i < 500; i++) begin
            step(1);
            checkOutput("hold_start", 32'(bus_a.start), 1);
            checkOutput("hold_timeout", 32'(bus_a.timeout), 0);
        end
        applyStimulus(1'b1, 1'b1);
        runs_a++;
        runs_b = (runs_b + 1) % 4;
        expectFall(cyc + 1, runs_a);
        step(1);
        applyStimulus(1'b0, 1'b0);
        waitIdle(10, "hold_idle_wait");
        checkOutput("hold_runs", 32'(bus_a.run_count), 5);
`endif

        step(5);
        checkOutput("pending_rise", exp_rise.size(), 0);
        checkOutput("pending_fall", exp_fall.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got cycle %0d, expected finish before it", cyc);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
